hamming74_rx_decoder: RTL and testbench

Receive-side counterpart of the Hamming-protected 4-bit universal register: accepts a Hamming(7,4) codeword, either as a parallel word or as a serial bit stream, then computes the syndrome, corrects any single-bit error and delivers the 4-bit payload over a valid/ready handshake. It sits downstream of the register's `serial_out`/`parallel_out`. It also maintains a saturating count of corrected errors for scrubbing statistics.

---
 rtl/hamming74_rx_decoder_pkg.sv | 54 +++++
 rtl/hamming74_rx_decoder_if.sv | 25 ++
 rtl/hamming74_rx_decoder_syndrome.sv | 45 ++++
 rtl/hamming74_rx_decoder.sv | 158 +++++++++++++++
 tb/tb_hamming74_rx_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming74_rx_decoder_pkg.sv
// Shared types, codeword layout constants and syndrome helpers for the
// Hamming(7,4) receive decoder.
// Build option: HAMMING_SECDED_EN widens codewords to 8 bits (adds overall parity p0).
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
    localparam int CW_W = 8;
`else
    localparam int CW_W = 7;
`endif

    // Codeword index i carries Hamming position i+1; index 7 is overall parity.
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D1_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int D2_IDX = 4;
    localparam int D3_IDX = 5;
    localparam int D4_IDX = 6;
    localparam int P0_IDX = 7;

    localparam int BCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2,
        HOLD   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic [3:0] data;
        logic       corr;
        logic [2:0] pos;
        logic       uncorr;
    } dec_result_t;

    // Syndrome {s4,s2,s1}; a nonzero value is the flipped Hamming position.
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[P1_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D4_IDX];
        s2 = cw[P2_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX] ^ cw[D4_IDX];
        s4 = cw[P4_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX] ^ cw[D4_IDX];
        return {s4, s2, s1};
    endfunction

    // Payload {d4,d3,d2,d1} pulled out of a 7-bit codeword.
    function automatic logic [3:0] hamming_extract(input logic [6:0] cw);
        return {cw[D4_IDX], cw[D3_IDX], cw[D2_IDX], cw[D1_IDX]};
    endfunction

endpackage

// File: rtl/hamming74_rx_decoder_if.sv
// Handshake bundle between the codeword source, the decoder and the payload
// consumer. The master side offers codewords and accepts payloads.
interface hamming74_rx_decoder_if;
    logic [7:0] cw_in;
    logic       cw_valid;
    logic       cw_ready;
    logic       serial_in;
    logic       serial_valid;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       err_corr;
    logic [2:0] err_pos;
    logic       err_uncorr;

    modport master (
        output cw_in, cw_valid, serial_in, serial_valid, data_ready,
        input  cw_ready, data_out, data_valid, err_corr, err_pos, err_uncorr
    );

    modport slave (
        input  cw_in, cw_valid, serial_in, serial_valid, data_ready,
        output cw_ready, data_out, data_valid, err_corr, err_pos, err_uncorr
    );
endinterface

// File: rtl/hamming74_rx_decoder_syndrome.sv
// Combinational Hamming syndrome, single-bit correction and payload extraction.
// Kept free of state so the encoder-side checker can reuse it.
// Build option: HAMMING_SECDED_EN adds overall-parity double-error detection.
module hamming74_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output dec_result_t     res
);

    logic [2:0] syn_s;
    logic [6:0] fixed_s;
`ifdef HAMMING_SECDED_EN
    logic       q_s;
`endif

    // Compute syndrome, flip the indicated bit and classify the error.
    always_comb begin
        syn_s = hamming_syndrome(cw[6:0]);
        for (int i = 0; i < 7; i++) begin
            fixed_s[i] = cw[i] ^ (syn_s == 3'(i + 1));
        end
`ifdef HAMMING_SECDED_EN
        q_s     = ^cw;
        res.pos = syn_s;
        if ((syn_s != 3'd0) && !q_s) begin
            // Even overall parity with a nonzero syndrome: two bits flipped.
            res.data   = hamming_extract(cw[6:0]);
            res.corr   = 1'b0;
            res.uncorr = 1'b1;
        end else begin
            // Single error in 1..7, or the p0 bit itself (syndrome 0, q=1).
            res.data   = hamming_extract(fixed_s);
            res.corr   = (syn_s != 3'd0) || q_s;
            res.uncorr = 1'b0;
        end
`else
        res.data   = hamming_extract(fixed_s);
        res.corr   = (syn_s != 3'd0);
        res.pos    = syn_s;
        res.uncorr = 1'b0;
`endif
    end

endmodule

// File: rtl/hamming74_rx_decoder.sv
// Hamming(7,4) receive decoder: captures a codeword in parallel or bit-serial,
// corrects single-bit errors, presents the payload on a valid/ready handshake
// and keeps a saturating corrected-error count.
// Build option: HAMMING_SECDED_EN (8-bit codewords with overall parity).
module hamming74_rx_decoder
    import hamming_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   ser_mode,
    input  logic                   cnt_clr,
    hamming74_rx_decoder_if.slave  bus,
    output logic [7:0]             corr_count
);

    rx_state_t         state_r;
    rx_state_t         state_s;
    logic [CW_W-1:0]   cw_r;
    logic [BCNT_W-1:0] bit_cnt_r;
    logic [BCNT_W-1:0] bit_cnt_s;
    logic              take_par_s;
    logic              shift_s;
    dec_result_t       dec_s;
    logic [3:0]        data_r;
    logic              err_corr_r;
    logic [2:0]        err_pos_r;
    logic              err_uncorr_r;
    logic [7:0]        corr_count_r;

`ifndef HAMMING_SECDED_EN
    // Bit 7 carries overall parity only in the extended build.
    logic              unused_cw_msb_s;
    assign unused_cw_msb_s = bus.cw_in[7];
`endif

    assign bus.cw_ready   = enable && (state_r == IDLE) && !ser_mode;
    assign bus.data_valid = (state_r == HOLD);
    assign bus.data_out   = data_r;
    assign bus.err_corr   = err_corr_r;
    assign bus.err_pos    = err_pos_r;
    assign bus.err_uncorr = err_uncorr_r;
    assign corr_count     = corr_count_r;

    hamming74_syndrome u_syndrome (
        .cw  (cw_r),
        .res (dec_s)
    );

    // Next-state and capture/shift control; everything holds while enable is low.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        take_par_s = 1'b0;
        shift_s    = 1'b0;
        if (enable) begin
            case (state_r)
                IDLE: begin
                    if (!ser_mode) begin
                        if (bus.cw_valid) begin
                            take_par_s = 1'b1;
                            state_s    = DECODE;
                        end else begin
                            state_s    = IDLE;
                        end
                    end else begin
                        if (bus.serial_valid) begin
                            shift_s   = 1'b1;
                            bit_cnt_s = 4'd1;
                            state_s   = SHIFT;
                        end else begin
                            state_s   = IDLE;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.serial_valid) begin
                        shift_s = 1'b1;
                        if (bit_cnt_r == 4'(CW_W - 1)) begin
                            bit_cnt_s = 4'd0;
                            state_s   = DECODE;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end
                DECODE: begin
                    state_s = HOLD;
                end
                HOLD: begin
                    if (bus.data_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s   = IDLE;
                    bit_cnt_s = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and bit-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
        end
    end

    // Codeword register: parallel load or LSB-first shift (first bit ends in cw[0]).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_r <= '0;
        end else if (take_par_s) begin
            cw_r <= bus.cw_in[CW_W-1:0];
        end else if (shift_s) begin
            cw_r <= {bus.serial_in, cw_r[CW_W-1:1]};
        end
    end

    // Latch the decode result once per codeword; held stable through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r       <= 4'd0;
            err_corr_r   <= 1'b0;
            err_pos_r    <= 3'd0;
            err_uncorr_r <= 1'b0;
        end else if (enable && (state_r == DECODE)) begin
            data_r       <= dec_s.data;
            err_corr_r   <= dec_s.corr;
            err_pos_r    <= dec_s.pos;
            err_uncorr_r <= dec_s.uncorr;
        end
    end

    // Saturating corrected-error counter; clear wins and works while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count_r <= 8'd0;
        end else if (cnt_clr) begin
            corr_count_r <= 8'd0;
        end else if (enable && (state_r == DECODE) && dec_s.corr &&
                     (corr_count_r != 8'hFF)) begin
            corr_count_r <= corr_count_r + 8'd1;
        end
    end

endmodule

// File: tb/tb_hamming74_rx_decoder.sv
// Self-checking bench for hamming74_rx_decoder: literal vector table, hand
// sequences for timing corners, and random codewords scored against a model
// that builds codewords from data and injected flips.
module tb_hamming74_rx_decoder;
    import hamming_pkg::*;

    typedef struct {
        logic [7:0] cw;
        logic [3:0] data;
        logic       corr;
        logic [2:0] pos;
        logic       uncorr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ser_mode;
    logic       cnt_clr;
    logic [7:0] corr_count;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    hamming74_rx_decoder_if bus();

    hamming74_rx_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ser_mode   (ser_mode),
        .cnt_clr    (cnt_clr),
        .bus        (bus),
        .corr_count (corr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: encode data, inject flips at Hamming positions (8 = p0), and
    // derive expected outputs from what was injected.
    function automatic vec_t make_vec(input logic [3:0] d, input int fa, input int fb);
        vec_t       v;
        logic [7:0] cw;
        int         n7;
        int         p0f;
        logic [2:0] px;
        int         fl[2];
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[7] = ^cw[6:0];
        n7 = 0; p0f = 0; px = 3'd0;
        fl[0] = fa; fl[1] = fb;
        for (int k = 0; k < 2; k++) begin
            if (fl[k] >= 1 && fl[k] <= 7) begin
                cw[fl[k]-1] = ~cw[fl[k]-1];
                n7++;
                px = px ^ 3'(fl[k]);
            end else if (fl[k] == 8) begin
                cw[7] = ~cw[7];
                p0f = 1;
            end
        end
        v.cw = cw;
        v.pos = px;
`ifdef HAMMING_SECDED_EN
        if (n7 == 2 || (n7 == 1 && p0f == 1)) begin
            v.uncorr = 1'b1;
            v.corr   = 1'b0;
            v.data   = {cw[6], cw[5], cw[4], cw[2]};
        end else begin
            v.uncorr = 1'b0;
            v.corr   = ((n7 + p0f) == 1);
            v.data   = d;
        end
`else
        v.uncorr = 1'b0;
        v.corr   = (n7 != 0);
        v.data   = d;
`endif
        return v;
    endfunction

    task automatic bump(input vec_t v);
        if (v.corr && exp_count < 255) exp_count++;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, ".data_out"},   bus.data_out,   v.data);
        chk({tag, ".err_corr"},   bus.err_corr,   v.corr);
        chk({tag, ".err_pos"},    bus.err_pos,    v.pos);
        chk({tag, ".err_uncorr"}, bus.err_uncorr, v.uncorr);
        chk({tag, ".corr_count"}, corr_count,     exp_count);
    endtask

    // Parallel transfer with latency checks; optional clear during DECODE.
    task automatic send_par(input vec_t v, input bit clr_in_decode);
        int w = 0;
        while (bus.cw_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("par.cw_ready", bus.cw_ready, 1);
        bus.cw_in = v.cw;
        bus.cw_valid = 1'b1;
        tick();
        bus.cw_valid = 1'b0;
        chk("par.decode_dv", bus.data_valid, 0);
        if (clr_in_decode) cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        if (clr_in_decode) exp_count = 0;
        else bump(v);
        chk("par.hold_dv", bus.data_valid, 1);
        check_result("par", v);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("par.exit_dv", bus.data_valid, 0);
        chk("par.ready_again", bus.cw_ready, 1);
    endtask

    // Serial transfer, LSB first, with random idle gaps between bits.
    task automatic send_ser(input vec_t v, input int max_gap);
        ser_mode = 1'b1;
        for (int i = 0; i < CW_W; i++) begin
            bus.serial_in = v.cw[i];
            bus.serial_valid = 1'b1;
            tick();
            bus.serial_valid = 1'b0;
            if (i < CW_W - 1) repeat ($urandom_range(0, max_gap)) tick();
        end
        ser_mode = 1'b0;
        chk("ser.decode_dv", bus.data_valid, 0);
        tick();
        bump(v);
        chk("ser.hold_dv", bus.data_valid, 1);
        check_result("ser", v);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("ser.exit_dv", bus.data_valid, 0);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   fa;

        tbl[0] = '{8'h55, 4'hB, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{8'h45, 4'hB, 1'b1, 3'd5, 1'b0};
        tbl[2] = '{8'h54, 4'hB, 1'b1, 3'd1, 1'b0};
        tbl[3] = '{8'h15, 4'hB, 1'b1, 3'd7, 1'b0};
        tbl[4] = '{8'hFF, 4'hF, 1'b0, 3'd0, 1'b0};
        tbl[5] = '{8'h00, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl[6] = '{8'h37, 4'h6, 1'b1, 3'd3, 1'b0};
`ifdef HAMMING_SECDED_EN
        tbl[7] = '{8'hD5, 4'hB, 1'b1, 3'd0, 1'b0};
`else
        tbl[7] = '{8'hD5, 4'hB, 1'b0, 3'd0, 1'b0};
`endif

        rst = 1'b1; enable = 1'b0; ser_mode = 1'b0; cnt_clr = 1'b0;
        bus.cw_in = 8'h00; bus.cw_valid = 1'b0; bus.serial_in = 1'b0;
        bus.serial_valid = 1'b0; bus.data_ready = 1'b0;
        repeat (3) tick();
        chk("reset.cw_ready",   bus.cw_ready,   0);
        chk("reset.data_valid", bus.data_valid, 0);
        chk("reset.data_out",   bus.data_out,   0);
        chk("reset.err_corr",   bus.err_corr,   0);
        chk("reset.err_pos",    bus.err_pos,    0);
        chk("reset.err_uncorr", bus.err_uncorr, 0);
        chk("reset.corr_count", corr_count,     0);
        rst = 1'b0;
        enable = 1'b1;
        tick();
        chk("post_reset.cw_ready", bus.cw_ready, 1);

        // Table-driven parallel vectors.
        for (int i = 0; i < 8; i++) send_par(tbl[i], 1'b0);

        // Serial all-ones frame with idle gaps and a 3-cycle freeze mid-frame.
        v = make_vec(4'hF, 0, 0);
        ser_mode = 1'b1;
        for (int i = 0; i < CW_W; i++) begin
            bus.serial_in = v.cw[i];
            bus.serial_valid = 1'b1;
            tick();
            bus.serial_valid = 1'b0;
            if (i == 1 || i == 4) tick();
            if (i == 3) begin
                enable = 1'b0;
                bus.serial_valid = 1'b1;
                bus.serial_in = 1'b0;
                repeat (3) tick();
                bus.serial_valid = 1'b0;
                enable = 1'b1;
                tick();
                chk("ser_freeze.no_early_dv", bus.data_valid, 0);
            end
        end
        ser_mode = 1'b0;
        tick();
        chk("ser_freeze.hold_dv", bus.data_valid, 1);
        check_result("ser_freeze", v);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;

        // HOLD stall: outputs stable, no ready; disabled cycle ignores data_ready.
        v = make_vec(4'h6, 3, 0);
        bus.cw_in = v.cw; bus.cw_valid = 1'b1;
        tick();
        bus.cw_valid = 1'b0;
        tick();
        bump(v);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.dv",       bus.data_valid, 1);
            chk("stall.data_out", bus.data_out,   v.data);
            chk("stall.err_pos",  bus.err_pos,    v.pos);
            chk("stall.cw_ready", bus.cw_ready,   0);
        end
        enable = 1'b0;
        bus.data_ready = 1'b1;
        tick();
        chk("stall.frozen_dv", bus.data_valid, 1);
        enable = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("stall.exit_dv", bus.data_valid, 0);
        chk("stall.cw_ready_next", bus.cw_ready, 1);

        // Random corrected words drive the count into saturation.
        for (int i = 0; i < 260; i++) begin
`ifdef HAMMING_SECDED_EN
            fa = $urandom_range(1, 8);
`else
            fa = $urandom_range(1, 7);
`endif
            send_par(make_vec(4'($urandom_range(0, 15)), fa, 0), 1'b0);
        end
        chk("sat.count", corr_count, 255);
        send_par(make_vec(4'hA, 2, 0), 1'b0);
        chk("sat.stays", corr_count, 255);
        send_par(make_vec(4'h5, 6, 0), 1'b1);
        chk("clr_wins.count", corr_count, 0);

        // Clear while disabled.
        send_par(make_vec(4'h3, 4, 0), 1'b0);
        enable = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        exp_count = 0;
        chk("clr_disabled.count", corr_count, 0);
        enable = 1'b1;

        // Reset after 4 serial bits discards the partial frame.
        send_par(make_vec(4'hC, 7, 0), 1'b0);
        ser_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = 1'b1;
            bus.serial_valid = 1'b1;
            tick();
        end
        bus.serial_valid = 1'b0;
        ser_mode = 1'b0;
        rst = 1'b1;
        #1;
        exp_count = 0;
        chk("rst_shift.dv",         bus.data_valid, 0);
        chk("rst_shift.data_out",   bus.data_out,   0);
        chk("rst_shift.err_corr",   bus.err_corr,   0);
        chk("rst_shift.err_pos",    bus.err_pos,    0);
        chk("rst_shift.corr_count", corr_count,     0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_shift.nothing_emitted", bus.data_valid, 0);
        end
        send_ser(make_vec(4'h9, 5, 0), 0);

        // Reset while a payload is pending in HOLD.
        v = make_vec(4'h7, 0, 0);
        bus.cw_in = v.cw; bus.cw_valid = 1'b1;
        tick();
        bus.cw_valid = 1'b0;
        tick();
        chk("rst_hold.pre_dv", bus.data_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_hold.dv", bus.data_valid, 0);
        chk("rst_hold.data_out", bus.data_out, 0);
        tick();
        rst = 1'b0;
        exp_count = 0;
        tick();
        chk("rst_hold.after_dv", bus.data_valid, 0);

        // Random serial frames with random gaps.
        for (int i = 0; i < 20; i++) begin
`ifdef HAMMING_SECDED_EN
            fa = $urandom_range(0, 8);
`else
            fa = $urandom_range(0, 7);
`endif
            send_ser(make_vec(4'($urandom_range(0, 15)), fa, 0), 2);
        end

`ifdef HAMMING_SECDED_EN
        // Double flip is flagged, not corrected, and not counted.
        send_par(make_vec(4'hB, 1, 2), 1'b0);
        chk("secded.uncorr", bus.err_uncorr, 1);
        send_ser(make_vec(4'h4, 3, 6), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
